// File: rtl/im_banked_if.sv
// Fetch/loader bus of the banked instruction memory: core fetch ports plus host loader port.
`ifndef NUM_C
`define NUM_C 4
`endif

interface im_banked_if #(
    parameter int unsigned NUM_C = `NUM_C,
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 16
);
    logic [NUM_C-1:0]    req;
    logic [NUM_C*AW-1:0] addr;
    logic [NUM_C-1:0]    gnt;
    logic [NUM_C-1:0]    rvalid;
    logic [NUM_C*DW-1:0] data_out;
    logic [NUM_C-1:0]    oor;
    logic                ld_we;
    logic [AW-1:0]       ld_addr;
    logic [DW-1:0]       ld_data;

    // Cores and the loader drive requests; memory answers.
    modport master (
        output req, addr, ld_we, ld_addr, ld_data,
        input  gnt, rvalid, data_out, oor
    );

    modport slave (
        input  req, addr, ld_we, ld_addr, ld_data,
        output gnt, rvalid, data_out, oor
    );
endinterface

// File: rtl/im_banked.sv
// Banked multi-core instruction memory: word-interleaved banks, per-bank round-robin
// arbitration with same-address merge, priority host loader, one-cycle read latency.
`ifndef NUM_C
`define NUM_C 4
`endif

module im_banked #(
    parameter int unsigned NUM_C     = `NUM_C,
    parameter int unsigned DW        = 16,
    parameter int unsigned AW        = 16,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned NUM_BANKS = 2
) (
    input  logic      clk,
    input  logic      rstn,
    im_banked_if.slave bus
);

    localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);
    localparam int unsigned BW        = (NUM_BANKS > 1) ? BANK_BITS : 1;
    localparam int unsigned ROWS      = DEPTH / NUM_BANKS;
    localparam int unsigned RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW        = (NUM_C > 1) ? $clog2(NUM_C) : 1;

    logic [DW-1:0]       mem_q [NUM_BANKS][ROWS];

    logic [AW-1:0]       addr_a [NUM_C];
    logic [BW-1:0]       bank_a [NUM_C];
    logic [RW-1:0]       row_a  [NUM_C];
    logic [NUM_C-1:0]    inr_c;
    logic [NUM_C-1:0]    cand_c [NUM_BANKS];

    logic [BW-1:0]       ld_bank_c;
    logic [RW-1:0]       ld_row_c;
    logic                ld_en_c;

    logic [NUM_C-1:0]    gnt_c;
    logic [CW-1:0]       ptr_q [NUM_BANKS];
    logic [CW-1:0]       ptr_d [NUM_BANKS];

    logic [NUM_C-1:0]    rvalid_q, rvalid_d;
    logic [NUM_C-1:0]    oor_q, oor_d;
    logic [NUM_C*DW-1:0] data_out_q, data_out_d;

    // Address decode: range check, bank/row split and per-bank candidate vectors.
    always_comb begin
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            cand_c[b] = '0;
        end
        for (int i = 0; i < int'(NUM_C); i++) begin
            addr_a[i] = bus.addr[i*AW +: AW];
            inr_c[i]  = 32'(addr_a[i]) < 32'(DEPTH);
            bank_a[i] = BW'(32'(addr_a[i]) % NUM_BANKS);
            row_a[i]  = RW'(32'(addr_a[i]) >> BANK_BITS);
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                cand_c[b][i] = bus.req[i] && inr_c[i] && (bank_a[i] == BW'(b));
            end
        end
        ld_bank_c = BW'(32'(bus.ld_addr) % NUM_BANKS);
        ld_row_c  = RW'(32'(bus.ld_addr) >> BANK_BITS);
        ld_en_c   = rstn && bus.ld_we && (32'(bus.ld_addr) < 32'(DEPTH));
    end

    // Per-bank round-robin winner, merge of same-address requesters, loader blocks its bank.
    always_comb begin
        logic        found;
        int unsigned win;
        int unsigned idx;
        found = 1'b0;
        win   = 0;
        idx   = 0;
        gnt_c = '0;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            ptr_d[b] = ptr_q[b];
        end
        if (rstn) begin
            // Out-of-range fetches bypass arbitration entirely.
            for (int i = 0; i < int'(NUM_C); i++) begin
                if (bus.req[i] && !inr_c[i]) begin
                    gnt_c[i] = 1'b1;
                end
            end
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                found = 1'b0;
                win   = 0;
                for (int k = 0; k < int'(NUM_C); k++) begin
                    idx = (32'(ptr_q[b]) + 32'(k)) % NUM_C;
                    if (!found && cand_c[b][idx]) begin
                        found = 1'b1;
                        win   = idx;
                    end
                end
                if (found && !(ld_en_c && (ld_bank_c == BW'(b)))) begin
                    for (int i = 0; i < int'(NUM_C); i++) begin
                        if (cand_c[b][i] && (addr_a[i] == addr_a[win])) begin
                            gnt_c[i] = 1'b1;
                        end
                    end
                    ptr_d[b] = CW'((win + 1) % NUM_C);
                end
            end
        end
    end

    // Response next-state: granted ports capture the bank word (or zero when out of range).
    always_comb begin
        rvalid_d   = gnt_c;
        oor_d      = gnt_c & ~inr_c;
        data_out_d = data_out_q;
        for (int i = 0; i < int'(NUM_C); i++) begin
            if (gnt_c[i]) begin
                data_out_d[i*DW +: DW] = inr_c[i] ? mem_q[bank_a[i]][row_a[i]] : '0;
            end
        end
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rvalid_q   <= '0;
            oor_q      <= '0;
            data_out_q <= '0;
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                ptr_q[b] <= '0;
            end
        end else begin
            rvalid_q   <= rvalid_d;
            oor_q      <= oor_d;
            data_out_q <= data_out_d;
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                ptr_q[b] <= ptr_d[b];
            end
        end
    end

    // Loader write port; storage is never reset.
    always_ff @(posedge clk) begin
        if (ld_en_c) begin
            mem_q[ld_bank_c][ld_row_c] <= bus.ld_data;
        end
    end

    assign bus.gnt      = gnt_c;
    assign bus.rvalid   = rvalid_q;
    assign bus.oor      = oor_q;
    assign bus.data_out = data_out_q;

endmodule

// File: doc/im_banked.md
# im_banked

Parametrised, banked, multi-core instruction memory; the successor of the single-array instruction memory in the multi-core processor. It serves `NUM_C` core fetch ports from `NUM_BANKS` word-interleaved single-port banks. Each bank has a per-bank round-robin arbiter. Requests from several cores for the same address are merged into one bank access. A host loader port writes program words at run time. Read latency is one cycle, unchanged from the previous generation.

## Interface

- `NUM_C`, default `` `NUM_C `` (4 in tests): number of core fetch ports.
- `DW`, default 16: instruction word width.
- `AW`, default 16: address width per port.
- `DEPTH`, default 1024: total words; must be a multiple of `NUM_BANKS`.
- `NUM_BANKS`, default 2: power of two, 1..`NUM_C`; bank = `addr[log2(NUM_BANKS)-1:0]`, row = `addr >> log2(NUM_BANKS)`.
- `clk` in 1: single clock, all state on posedge.
- `rstn` in 1: synchronous, active-low reset.
- `req` in `NUM_C`: per-core fetch request; held with `addr` until granted.
- `addr` in `NUM_C*AW`: packed fetch addresses, core i at `[i*AW +: AW]`.
- `gnt` out `NUM_C`: combinational grant, same cycle as the accepted `req`.
- `rvalid` out `NUM_C`: registered; data for the request granted in the previous cycle.
- `data_out` out `NUM_C*DW`: registered, packed like `addr`; holds its value while `rvalid`=0.
- `oor` out `NUM_C`: registered; qualifies `rvalid`, set when the address was ≥ `DEPTH`.
- `ld_we` in 1: loader write strobe.
- `ld_addr` in `AW`: loader word address.
- `ld_data` in `DW`: loader write data.

## Operation

- **Reset** (`rstn`=0 at a posedge): `rvalid`=0, `oor`=0, `data_out`=0, all round-robin pointers=0. While `rstn`=0, `gnt`=0 and `ld_we` is ignored. Memory contents are not reset.
- **Loader**
  - `ld_we`=1 with `ld_addr` < `DEPTH` writes `ld_data` at the edge, into the bank and row decoded from `ld_addr`.
  - The loader has absolute priority: that bank grants no core in that cycle.
  - Out-of-range loader writes are dropped silently.
- **Arbitration per bank**, each cycle:
  - The candidates are cores with `req`=1, an in-range address, and that bank decoded.
  - The winner is the first candidate at or after the bank pointer, searching in increasing index order with wrap.
  - **Merge:** every other candidate whose address equals the winner's address is also granted and receives the same word.
  - After any grant, the pointer moves to winner index + 1, mod `NUM_C`. With no grant, the pointer holds. Merged cores do not affect the pointer.
- **Out-of-range fetch:** an address ≥ `DEPTH` is granted immediately without arbitration. It returns `data_out`=0 with `oor`=1.
- Banks are independent. Up to `NUM_BANKS` distinct addresses are served per cycle, plus any merged duplicates.
- **Same-bank read/write:** a loader write and a core read never hit the same bank in the same cycle, so no read-during-write case exists.

## Timing

- `req[i]` and `gnt[i]` both high in cycle N → `rvalid[i]`=1 in cycle N+1, with `data_out[i]` = memory word as of the edge ending cycle N.
- A core may assert a new `req` in cycle N+1 (back-to-back fetch, one word per cycle per core when there is no conflict).
- An ungranted request must stay stable. `gnt` may arrive in any later cycle; there is no timeout.
- A word written by the loader at edge E is readable by a grant in the cycle that starts at E.
- **Reset mid-operation:** if `rstn`=0 in cycle N+1, the pending `rvalid` is cleared at that edge and its data is discarded.
- **Worst-case latency:** for a core contending alone on a bank with the other `NUM_C`-1 cores and no loader traffic, grant comes within `NUM_C` cycles.

## Test plan

- **Load and fetch:** load the words 6, 0, 45, 27, 44, 43 at addresses 0–5. Then core 0 requests address 2 → `gnt`=0001 same cycle; next cycle `rvalid[0]`=1, `data_out[0]`=45, `oor[0]`=0.
- **Bank conflict:** cores 0–3 request addresses 0, 1, 2, 3 (banks 0, 1, 0, 1) and keep requesting until granted.
  - Cycle 1: `gnt`=0011.
  - Cycle 2: `gnt`=1100.
  - Returned data = words at addresses 0–3.
- **Fairness and merge:**
  - Cores 0 and 2 continuously request addresses 0 and 4 respectively → grants alternate 0, 2, 0, 2.
  - All four cores request address 4 → `gnt`=1111 in a single cycle, all four `data_out` equal.
- **Loader priority:** `ld_we`=1, `ld_addr`=4, `ld_data`=17, while core 0 requests address 6 and core 1 requests address 5.
  - Cycle 1: `gnt`=0010.
  - Cycle 2: `gnt[0]`=1.
  - A subsequent fetch of address 4 returns 17.
- **Out of range:** core 3 requests address 2000 → `gnt[3]`=1 same cycle, even with a bank-0 loader write active. Next cycle: `rvalid[3]`=1, `oor[3]`=1, `data_out[3]`=0.
- **Reset mid-operation:** grant core 1 in cycle N, then drive `rstn`=0 in cycle N+1 → at that edge `rvalid`=0 and `data_out`=0. After release, a fetch from core 0 wins under pointer 0.
